// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the memory arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    function automatic logic addr_oob(input logic [ADDR_W-1:0] addr, input int size);
        return ({{(32-ADDR_W){1'b0}}, addr} >= size[31:0]);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - two-input round-robin picker with last-winner pointer
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_if,
    input  logic req_d,
    input  logic take,
    output logic pick
);

    logic last_q;
    logic last_d;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        pick = REQ_IF;
        if (req_d && (!req_if || (last_q == REQ_IF))) begin
            pick = REQ_D;
        end
    end

    always_comb begin
        last_d = last_q;
        if (take) begin
            last_d = pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch / load-store arbiter and sequencer for the single-port data memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEMORY_SIZE = 2048,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              arb_take;
    logic              arb_pick;
    logic [ADDR_W-1:0] win_addr;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst),
        .req_if (if_req),
        .req_d  (d_req),
        .take   (arb_take),
        .pick   (arb_pick)
    );

    assign win_addr = (arb_pick == REQ_D) ? d_addr : if_addr;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        arb_take = 1'b0;
        case (state_q)
            // RESP arbitrates exactly like IDLE so back-to-back accesses lose no cycle.
            IDLE, RESP: begin
                state_d = IDLE;
                if (if_req || d_req) begin
                    arb_take = 1'b1;
                    owner_d  = arb_pick;
                    addr_d   = win_addr;
                    err_d    = addr_oob(win_addr, MEMORY_SIZE);
                    if (arb_pick == REQ_D) begin
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    rdata_d = (we_q || err_q) ? '0 : mem_rdata;
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= REQ_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs are pure decodes of registered state, so nothing is combinational from inputs.
    logic in_issue;
    logic in_resp;

    assign in_issue  = (state_q == ISSUE);
    assign in_resp   = (state_q == RESP);

    assign if_gnt    = in_issue && (owner_q == REQ_IF);
    assign d_gnt     = in_issue && (owner_q == REQ_D);

    assign mem_en    = in_issue && !err_q;
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign if_rvalid = in_resp && (owner_q == REQ_IF);
    assign if_rdata  = if_rvalid ? rdata_q : '0;
    assign if_err    = if_rvalid && err_q;

    assign d_done    = in_resp && (owner_q == REQ_D);
    assign d_rdata   = d_done ? rdata_q : '0;
    assign d_err     = d_done && err_q;

endmodule
